// File: rtl/connect_suite_crossing_pipe.sv
// Lane-parallel adder (o1 = i1, o2 = o1 + i2) feeding a first-word fall-through result FIFO.
// Optional macro CROSSING_PIPE_CHAIN_EN chains o2 of lane k-1 into lane k in place of i2.
module connect_suite_crossing_pipe #(
   parameter int W     = 8,
   parameter int CH    = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       io_in_valid,
   output logic                       io_in_ready,
   input  logic [CH*W-1:0]            io_in_i1,
   input  logic [CH*W-1:0]            io_in_i2,
   output logic                       io_out_valid,
   input  logic                       io_out_ready,
   output logic [CH*W-1:0]            io_out_o1,
   output logic [CH*W-1:0]            io_out_o2,
   input  logic                       io_flush,
   output logic [$clog2(DEPTH):0]     io_count,
   output logic [1:0]                 o_dbg_state
);
   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // ready never depends on the same-cycle pop, so a full FIFO refuses input even if drained.
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic [CH*W-1:0] r_mem_o1 [DEPTH];
   logic [CH*W-1:0] r_mem_o2 [DEPTH];
   logic [CH*W-1:0] w_o2;
   logic [W-1:0]    w_add;
   logic [W-1:0]    w_prev;
   logic            w_push;
   logic            w_pop;

   assign io_in_ready  = (r_count < FULL_CNT) & ~io_flush;
   assign io_out_valid = (r_count != '0);
   assign w_push       = io_in_valid & io_in_ready;
   assign w_pop        = io_out_valid & io_out_ready;
   assign io_count     = r_count;
   assign o_dbg_state  = r_state;
   assign io_out_o1    = io_out_valid ? r_mem_o1[r_rd_ptr] : '0;
   assign io_out_o2    = io_out_valid ? r_mem_o2[r_rd_ptr] : '0;

   // Per-lane sum; the chained build ripples lane k-1's wrapped sum into lane k.
   always_comb begin
      w_o2   = '0;
      w_prev = '0;
      w_add  = '0;
      for (int k = 0; k < CH; k++) begin
`ifdef CROSSING_PIPE_CHAIN_EN
         w_add = (k == 0) ? io_in_i2[k*W +: W] : w_prev;
`else
         w_add = io_in_i2[k*W +: W];
`endif
         w_prev          = io_in_i1[k*W +: W] + w_add;
         w_o2[k*W +: W]  = w_prev;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (io_flush) begin
         w_count_nxt = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
         endcase
      end
      if (w_count_nxt == '0) begin
         w_state_nxt = ST_EMPTY;
      end else if (w_count_nxt == FULL_CNT) begin
         w_state_nxt = ST_FULL;
      end else begin
         w_state_nxt = ST_PARTIAL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= ST_EMPTY;
      end else if (io_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= ST_EMPTY;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_state <= w_state_nxt;
      end
   end

   // Storage needs no reset: outputs are masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_mem_o1[r_wr_ptr] <= io_in_i1;
         r_mem_o2[r_wr_ptr] <= w_o2;
      end
   end

endmodule

// File: tb/tb_connect_suite_crossing_pipe.sv
// Self-checking bench for connect_suite_crossing_pipe: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_connect_suite_crossing_pipe;
   localparam int W     = 8;
   localparam int CH    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            io_in_valid;
   logic            io_in_ready;
   logic [CH*W-1:0] io_in_i1;
   logic [CH*W-1:0] io_in_i2;
   logic            io_out_valid;
   logic            io_out_ready;
   logic [CH*W-1:0] io_out_o1;
   logic [CH*W-1:0] io_out_o2;
   logic            io_flush;
   logic [CW-1:0]   io_count;
   logic [1:0]      o_dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [CH*W-1:0] exp_o1_q[$];
   logic [CH*W-1:0] exp_o2_q[$];

   connect_suite_crossing_pipe #(.W(W), .CH(CH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
      .io_in_i1(io_in_i1), .io_in_i2(io_in_i2),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_out_o1(io_out_o1), .io_out_o2(io_out_o2),
      .io_flush(io_flush), .io_count(io_count), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [CH*W-1:0] rand_set();
      logic [CH*W-1:0] v;
      v = '0;
      for (int k = 0; k < CH; k++) v[k*W +: W] = W'($urandom_range(0, (1 << W) - 1));
      return v;
   endfunction

   // Reference rule: each lane adds its operand modulo 2^W; chained build feeds lane k-1's result.
   function automatic logic [CH*W-1:0] model_o2(input logic [CH*W-1:0] a, input logic [CH*W-1:0] b);
      logic [CH*W-1:0] r;
      int prev;
      int opnd;
      int s;
      r = '0;
      prev = 0;
      for (int k = 0; k < CH; k++) begin
`ifdef CROSSING_PIPE_CHAIN_EN
         opnd = (k == 0) ? int'(b[k*W +: W]) : prev;
`else
         opnd = int'(b[k*W +: W]);
`endif
         s = (int'(a[k*W +: W]) + opnd) % (1 << W);
         r[k*W +: W] = W'(s);
         prev = s;
      end
      return r;
   endfunction

   function automatic logic [1:0] model_state(input int n);
      if (n == 0) return 2'd0;
      if (n == DEPTH) return 2'd2;
      return 2'd1;
   endfunction

   task automatic drive(input logic v, input logic [CH*W-1:0] a, input logic [CH*W-1:0] b,
                        input logic ordy, input logic fl, input logic rst);
      io_in_valid  = v;
      io_in_i1     = a;
      io_in_i2     = b;
      io_out_ready = ordy;
      io_flush     = fl;
      reset        = rst;
      #1;
   endtask

   // Advance one clock, updating the model from the inputs presented during that cycle.
   task automatic tick();
      bit p;
      bit q;
      @(posedge clk);
      if (reset || io_flush) begin
         exp_o1_q.delete();
         exp_o2_q.delete();
      end else begin
         p = io_in_valid && (exp_o1_q.size() < DEPTH);
         q = io_out_ready && (exp_o1_q.size() > 0);
         if (q) begin
            void'(exp_o1_q.pop_front());
            void'(exp_o2_q.pop_front());
         end
         if (p) begin
            exp_o1_q.push_back(io_in_i1);
            exp_o2_q.push_back(model_o2(io_in_i1, io_in_i2));
         end
      end
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && exp_o1_q.size() > 0; i++) begin
         drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(1'b1, rand_set(), rand_set(), 1'b1, 1'b0, 1'b1);
      tick();
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", io_out_valid); end
      checks++; if (io_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", io_in_ready); end
      checks++; if (io_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", io_count); end
      checks++; if (io_out_o1 !== '0 || io_out_o2 !== '0) begin failures++; $display("FAIL reset_outs o1=%h o2=%h exp=0", io_out_o1, io_out_o2); end
      checks++; if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_dbg_state); end
   endtask

   task automatic test_basic();
      logic [CH*W-1:0] exp_o2;
`ifdef CROSSING_PIPE_CHAIN_EN
      exp_o2 = 32'h0B070402;
`else
      exp_o2 = 32'h05040302;
`endif
      drive(1'b1, 32'h04030201, 32'h01010101, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", io_out_valid); end
      checks++; if (io_out_o1 !== 32'h04030201) begin failures++; $display("FAIL basic_o1 got=%h exp=04030201", io_out_o1); end
      checks++; if (io_out_o2 !== exp_o2) begin failures++; $display("FAIL basic_o2 got=%h exp=%h", io_out_o2, exp_o2); end
      checks++; if (io_count !== CW'(1)) begin failures++; $display("FAIL basic_count got=%0d exp=1", io_count); end
      drain();
   endtask

   task automatic test_wrap();
      drive(1'b1, 32'h000000FF, 32'h00000002, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_out_o2[7:0] !== 8'h01) begin failures++; $display("FAIL wrap_lane0 got=%h exp=01", io_out_o2[7:0]); end
      drain();
   endtask

   task automatic test_full();
      logic [CH*W-1:0] first;
      logic [CH*W-1:0] second;
      first  = rand_set();
      second = rand_set();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, (i == 0) ? first : ((i == 1) ? second : rand_set()), rand_set(), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, rand_set(), rand_set(), 1'b0, 1'b0, 1'b0);
      checks++; if (io_count !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", io_count, DEPTH); end
      checks++; if (io_in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", io_in_ready); end
      checks++; if (o_dbg_state !== 2'd2) begin failures++; $display("FAIL full_state got=%0d exp=2", o_dbg_state); end
      tick();
      checks++; if (io_count !== CW'(DEPTH)) begin failures++; $display("FAIL full_5th_count got=%0d exp=%0d", io_count, DEPTH); end
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (io_out_o1 !== first) begin failures++; $display("FAIL full_head got=%h exp=%h", io_out_o1, first); end
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_in_ready got=%b exp=1", io_in_ready); end
      checks++; if (io_out_o1 !== second || io_count !== CW'(DEPTH - 1)) begin
         failures++; $display("FAIL full_pop_next head=%h exp=%h count=%0d exp=%0d", io_out_o1, second, io_count, DEPTH - 1);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, rand_set(), rand_set(), 1'b0, 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, rand_set(), rand_set(), 1'b1, 1'b0, 1'b0);
         checks++; if (io_out_o1 !== exp_o1_q[0] || io_out_o2 !== exp_o2_q[0]) begin
            failures++; $display("FAIL b2b_head cyc=%0d o1=%h exp=%h o2=%h exp=%h", i, io_out_o1, exp_o1_q[0], io_out_o2, exp_o2_q[0]);
         end
         tick();
         checks++; if (io_count !== CW'(2)) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=2", i, io_count); end
      end
      drain();
   endtask

   task automatic test_flush();
      logic [CH*W-1:0] fresh;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rand_set(), rand_set(), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, rand_set(), rand_set(), 1'b1, 1'b1, 1'b0);
      checks++; if (io_in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", io_in_ready); end
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_count !== '0 || io_out_valid !== 1'b0) begin
         failures++; $display("FAIL flush_empty count=%0d valid=%b exp=0/0", io_count, io_out_valid);
      end
      checks++; if (io_out_o1 !== '0) begin failures++; $display("FAIL flush_o1 got=%h exp=0", io_out_o1); end
      fresh = rand_set();
      drive(1'b1, fresh, rand_set(), 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_out_o1 !== fresh || io_count !== CW'(1)) begin
         failures++; $display("FAIL flush_refill head=%h exp=%h count=%0d exp=1", io_out_o1, fresh, io_count);
      end
      drain();
   endtask

   task automatic test_midstream_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rand_set(), rand_set(), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, rand_set(), rand_set(), 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_count !== '0 || io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
         failures++; $display("FAIL midreset count=%0d valid=%b ready=%b exp=0/0/1", io_count, io_out_valid, io_in_ready);
      end
   endtask

`ifdef CROSSING_PIPE_CHAIN_EN
   task automatic test_chain();
      logic [CH*W-1:0] b;
      b = rand_set();
      b[7:0] = 8'h02;
      drive(1'b1, 32'h01010101, b, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (io_out_o2 !== 32'h06050403 || io_out_o1 !== 32'h01010101) begin
         failures++; $display("FAIL chain o1=%h exp=01010101 o2=%h exp=06050403", io_out_o1, io_out_o2);
      end
      drain();
   endtask
`endif

   task automatic test_random();
      int n;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, rand_set(), rand_set(), $urandom_range(0, 9) < 6,
               $urandom_range(0, 29) == 0, 1'b0);
         n = exp_o1_q.size();
         checks++; if (io_in_ready !== ((n < DEPTH) && !io_flush)) begin
            failures++; $display("FAIL rand_in_ready cyc=%0d got=%b n=%0d flush=%b", i, io_in_ready, n, io_flush);
         end
         tick();
         n = exp_o1_q.size();
         checks++; if (io_count !== CW'(n) || io_out_valid !== (n != 0) || o_dbg_state !== model_state(n)) begin
            failures++; $display("FAIL rand_occupancy cyc=%0d count=%0d valid=%b state=%0d exp_n=%0d", i, io_count, io_out_valid, o_dbg_state, n);
         end
         checks++;
         if (n > 0) begin
            if (io_out_o1 !== exp_o1_q[0] || io_out_o2 !== exp_o2_q[0]) begin
               failures++; $display("FAIL rand_head cyc=%0d o1=%h exp=%h o2=%h exp=%h", i, io_out_o1, exp_o1_q[0], io_out_o2, exp_o2_q[0]);
            end
         end else if (io_out_o1 !== '0 || io_out_o2 !== '0) begin
            failures++; $display("FAIL rand_empty_outs cyc=%0d o1=%h o2=%h exp=0", i, io_out_o1, io_out_o2);
         end
      end
      drain();
   endtask

   initial begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      test_reset();
      test_basic();
      test_wrap();
      test_full();
      test_back_to_back();
      test_flush();
      test_midstream_reset();
`ifdef CROSSING_PIPE_CHAIN_EN
      test_chain();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
